simd_alu_pipe_param: RTL and testbench

- Parameterised, pipelined successor of the fixed two-slice 27/18-bit SIMD post-adder ALU.
- Datapath is NUM_SEG × SEG_WIDTH bits, split at run time into one full-width lane, two lanes, or NUM_SEG independent segment lanes.
- Adds an input register stage, a result (P) register, accumulate feedback and a valid pipeline.
- Sits after the multiplier partial-product stage in the PIRDSP slice.

---
 rtl/simd_alu_pipe_param.sv | 142 ++++++++++++++
 tb/tb_simd_alu_pipe_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe_param.sv
// simd_alu_pipe_param
// Two-stage SIMD post-adder ALU. The datapath is NUM_SEG segments of SEG_WIDTH
// bits, split at run time into one lane, two lanes (cut at SPLIT_SEG) or one
// lane per segment. Stage 1 registers the operands. Stage 2 computes
// Zs +/- (W+X+Y+CIN) or a bitwise Zs op X and loads P. Zs may be P itself,
// which gives bubble-free accumulation.
module simd_alu_pipe_param #(
  parameter int NUM_SEG   = 5,
  parameter int SEG_WIDTH = 9,
  parameter int SPLIT_SEG = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [NUM_SEG*SEG_WIDTH-1:0]   W,
  input  logic [NUM_SEG*SEG_WIDTH-1:0]   X,
  input  logic [NUM_SEG*SEG_WIDTH-1:0]   Y,
  input  logic [NUM_SEG*SEG_WIDTH-1:0]   Z,
  input  logic                           CIN,
  input  logic [1:0]                     op,
  input  logic                           sub,
  input  logic [1:0]                     simd_mode,
  input  logic                           acc_en,
  input  logic                           clr,
  output logic                           out_valid,
  output logic [NUM_SEG*SEG_WIDTH-1:0]   P,
  output logic [NUM_SEG-1:0]             carry_out
);

  localparam int DW = NUM_SEG * SEG_WIDTH;
  localparam int SW = SEG_WIDTH;

  logic          s1_valid;
  logic [DW-1:0] s1_w, s1_x, s1_y, s1_z;
  logic          s1_cin, s1_sub, s1_acc;
  logic [1:0]    s1_op, s1_mode;

  logic [DW-1:0]      zs;
  logic [DW-1:0]      res;
  logic [NUM_SEG-1:0] res_carry;
  logic [SW+1:0]      t_sum;
  logic [SW:0]        r_sum;
  logic [1:0]         t_c;
  logic               r_c;
  logic               lane_start, lane_end;
  logic               mode_two, mode_seg;

  // Stage 1: capture operands and controls whenever in_valid is high
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset as well, so stage 2 never computes on X after reset.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_w     <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
      s1_cin   <= 1'b0;
      s1_sub   <= 1'b0;
      s1_acc   <= 1'b0;
      s1_op    <= 2'b00;
      s1_mode  <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples its pre-edge inputs.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_w    <= W;
        s1_x    <= X;
        s1_y    <= Y;
        s1_z    <= Z;
        s1_cin  <= CIN;
        s1_sub  <= sub;
        s1_acc  <= acc_en;
        s1_op   <= op;
        s1_mode <= simd_mode;
      end
    end
  end

  assign zs       = s1_acc ? P : s1_z;
  assign mode_two = (s1_mode == 2'b01);
  assign mode_seg = (s1_mode == 2'b10);

  // Stage 2 datapath: segment-serial T and R carry chains, restarted at each lane start
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the loop can infer a latch.
    res        = '0;
    res_carry  = '0;
    t_sum      = '0;
    r_sum      = '0;
    t_c        = 2'b00;
    r_c        = 1'b0;
    lane_start = 1'b0;
    lane_end   = 1'b0;
    case (s1_op)
      2'b01:   res = zs ^ s1_x;
      2'b10:   res = zs & s1_x;
      2'b11:   res = zs | s1_x;
      default: begin
        for (int i = 0; i < NUM_SEG; i++) begin
          lane_start = (i == 0) || mode_seg || (mode_two && (i == SPLIT_SEG));
          lane_end   = (i == NUM_SEG - 1) || mode_seg || (mode_two && (i == SPLIT_SEG - 1));
          if (lane_start) begin
            t_c = (i == 0) ? {1'b0, s1_cin} : 2'b00;
            r_c = 1'b0;
          end
          // T digit: three operands plus a carry of up to 2 from the segment below
          t_sum = {2'b00, s1_w[i*SW +: SW]} + {2'b00, s1_x[i*SW +: SW]}
                + {2'b00, s1_y[i*SW +: SW]} + {{SW{1'b0}}, t_c};
          t_c   = t_sum[SW+1:SW];
          // R digit: Zs plus or minus the T digit, with a one-bit carry or borrow
          if (s1_sub)
            r_sum = {1'b0, zs[i*SW +: SW]} - {1'b0, t_sum[SW-1:0]} - {{SW{1'b0}}, r_c};
          else
            r_sum = {1'b0, zs[i*SW +: SW]} + {1'b0, t_sum[SW-1:0]} + {{SW{1'b0}}, r_c};
          r_c = r_sum[SW];
          res[i*SW +: SW] = r_sum[SW-1:0];
          // Overflow beyond the lane comes from the R chain or from the high part of T
          if (lane_end) res_carry[i] = r_c || (t_c != 2'b00);
        end
      end
    endcase
  end

  // Stage 2 register: clr wins over a load; out_valid follows s1_valid either way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      P         <= '0;
      carry_out <= '0;
    end else begin
      out_valid <= s1_valid;
      if (clr) begin
        P         <= '0;
        carry_out <= '0;
      end else if (s1_valid) begin
        P         <= res;
        carry_out <= res_carry;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe_param.sv
// Testbench for simd_alu_pipe_param at its default parameters (5 x 9 bits,
// two-lane split at segment 3). It runs directed scenarios and then a random
// stream. The random stream is compared with a lane-level integer model.
module tb_simd_alu_pipe_param;

  localparam int NS    = 5;
  localparam int SW    = 9;
  localparam int SPLIT = 3;
  localparam int DW    = NS * SW;

  typedef struct {
    logic          v;
    logic [DW-1:0] w, x, y, z;
    logic          cin;
    logic [1:0]    op;
    logic          sub;
    logic [1:0]    mode;
    logic          acc;
  } txn_t;

  logic          clk, rst_n, in_valid, cin, sub, acc_en, clr;
  logic [DW-1:0] w, x, y, z;
  logic [1:0]    op, simd_mode;
  logic          out_valid;
  logic [DW-1:0] p;
  logic [NS-1:0] carry_out;

  int errors = 0;
  int checks = 0;

  simd_alu_pipe_param #(.NUM_SEG(NS), .SEG_WIDTH(SW), .SPLIT_SEG(SPLIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .W(w), .X(x), .Y(y), .Z(z), .CIN(cin), .op(op), .sub(sub),
    .simd_mode(simd_mode), .acc_en(acc_en), .clr(clr),
    .out_valid(out_valid), .P(p), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic txn_t mk(input logic v, input logic [DW-1:0] tw, tx, ty, tz,
                              input logic tcin, input logic [1:0] top, input logic tsub,
                              input logic [1:0] tmode, input logic tacc);
    txn_t t;
    t.v = v; t.w = tw; t.x = tx; t.y = ty; t.z = tz; t.cin = tcin;
    t.op = top; t.sub = tsub; t.mode = tmode; t.acc = tacc;
    return t;
  endfunction

  function automatic txn_t idle_t();
    return mk(1'b0, '0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
  endfunction

  task automatic apply(input txn_t t, input logic clr_i);
    in_valid  = t.v;
    w         = t.w;
    x         = t.x;
    y         = t.y;
    z         = t.z;
    cin       = t.cin;
    op        = t.op;
    sub       = t.sub;
    simd_mode = t.mode;
    acc_en    = t.acc;
    clr       = clr_i;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[DW-1:0];
  endfunction

  // Lane-level reference: each lane is treated as a plain integer of width L
  task automatic model_calc(input txn_t t, input logic [DW-1:0] p_cur,
                            output logic [DW-1:0] r, output logic [NS-1:0] co);
    int lo_s[$];
    int hi_s[$];
    logic [DW-1:0] zsel;
    longint acc, mask, wv, xv, yv, zv, tt, rr;
    int lo, len;
    zsel = t.acc ? p_cur : t.z;
    co   = '0;
    r    = '0;
    if (t.op != 2'b00) begin
      case (t.op)
        2'b01:   r = zsel ^ t.x;
        2'b10:   r = zsel & t.x;
        default: r = zsel | t.x;
      endcase
    end else begin
      case (t.mode)
        2'b01: begin lo_s = '{0, SPLIT}; hi_s = '{SPLIT - 1, NS - 1}; end
        2'b10: for (int s = 0; s < NS; s++) begin lo_s.push_back(s); hi_s.push_back(s); end
        default: begin lo_s = '{0}; hi_s = '{NS - 1}; end
      endcase
      acc = 0;
      for (int j = 0; j < lo_s.size(); j++) begin
        lo   = lo_s[j] * SW;
        len  = (hi_s[j] - lo_s[j] + 1) * SW;
        mask = (longint'(1) << len) - 1;
        wv   = (longint'(t.w) >> lo) & mask;
        xv   = (longint'(t.x) >> lo) & mask;
        yv   = (longint'(zsel) >> 0) & 0;
        zv   = (longint'(zsel) >> lo) & mask;
        yv   = (longint'(t.y) >> lo) & mask;
        tt   = wv + xv + yv + ((lo_s[j] == 0) ? longint'(t.cin) : 0);
        rr   = t.sub ? (zv - tt) : (zv + tt);
        acc  = acc | ((rr & mask) << lo);
        co[hi_s[j]] = t.sub ? (rr < 0) : (rr > mask);
      end
      r = acc[DW-1:0];
    end
  endtask

  task automatic test_reset();
    apply(idle_t(), 1'b0);
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (p !== '0) begin errors++; $display("FAIL reset_p: got %h want 0", p); end
    checks++; if (carry_out !== '0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_sum();
    @(negedge clk); apply(mk(1'b1, 45'd3, 45'd1, 45'd2, 45'd10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0), 1'b0);
    @(negedge clk); apply(idle_t(), 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_sum_valid: got %b want 1", out_valid); end
    checks++; if (p !== 45'd17) begin errors++; $display("FAIL full_sum_p: got %h want %h", p, 45'd17); end
    checks++; if (carry_out !== 5'b00000) begin errors++; $display("FAIL full_sum_carry: got %b want 00000", carry_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_sum_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_lane_isolation();
    logic [DW-1:0] x_all, z_all;
    x_all = {NS{9'h1FF}};
    z_all = {NS{9'h001}};
    @(negedge clk); apply(mk(1'b1, '0, x_all, '0, z_all, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0), 1'b0);
    @(negedge clk); apply(mk(1'b1, '0, x_all, '0, z_all, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 1'b0);
    @(negedge clk); apply(idle_t(), 1'b0);
    checks++; if (p !== '0) begin errors++; $display("FAIL lanes_seg_p: got %h want 0", p); end
    checks++; if (carry_out !== 5'b11111) begin errors++; $display("FAIL lanes_seg_carry: got %b want 11111", carry_out); end
    @(negedge clk);
    // One 45-bit lane: Z + (2^45 - 1) wraps to Z - 1 with a carry at the top
    checks++; if (p !== 45'h1008040200) begin errors++; $display("FAIL lanes_one_p: got %h want %h", p, 45'h1008040200); end
    checks++; if (carry_out !== 5'b10000) begin errors++; $display("FAIL lanes_one_carry: got %b want 10000", carry_out); end
  endtask

  task automatic test_two_lane_sub();
    @(negedge clk); apply(mk(1'b1, '0, 45'd1, '0, '0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0), 1'b0);
    @(negedge clk); apply(idle_t(), 1'b0);
    @(negedge clk);
    checks++; if (p !== 45'h0007FFFFFF) begin errors++; $display("FAIL two_lane_p: got %h want %h", p, 45'h0007FFFFFF); end
    checks++; if (carry_out !== 5'b00100) begin errors++; $display("FAIL two_lane_carry: got %b want 00100", carry_out); end
  endtask

  task automatic test_logic();
    logic [DW-1:0] exp_p [3];
    logic [1:0]    ops   [3];
    ops   = '{2'b10, 2'b11, 2'b01};
    exp_p = '{45'h0F0, 45'h0FF, 45'h00F};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++; if (p !== exp_p[0]) begin errors++; $display("FAIL logic_p%0d: got %h want %h", 0, p, exp_p[0]); end
        checks++; if (carry_out !== '0) begin errors++; $display("FAIL logic_carry%0d: got %b want 0", 0, carry_out); end
      end
      apply(mk(1'b1, rand_word(), 45'h0FF, rand_word(), 45'h0F0, 1'b1, ops[i], 1'b1,
               2'($urandom_range(0, 3)), 1'b0), 1'b0);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); apply(idle_t(), 1'b0);
      checks++; if (p !== exp_p[i]) begin errors++; $display("FAIL logic_p%0d: got %h want %h", i, p, exp_p[i]); end
      checks++; if (carry_out !== '0) begin errors++; $display("FAIL logic_carry%0d: got %b want 0", i, carry_out); end
    end
  endtask

  task automatic test_accumulate();
    logic          exp_v [7];
    logic [DW-1:0] exp_p [7];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_p = '{45'd0, 45'd0, 45'd1, 45'd2, 45'd3, 45'd4, 45'd4};
    @(negedge clk); apply(idle_t(), 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== exp_v[i]) begin errors++; $display("FAIL acc_valid%0d: got %b want %b", i, out_valid, exp_v[i]); end
      checks++; if (p !== exp_p[i]) begin errors++; $display("FAIL acc_p%0d: got %h want %h", i, p, exp_p[i]); end
      if (i < 4) apply(mk(1'b1, '0, 45'd1, '0, rand_word(), 1'b0, 2'b00, 1'b0, 2'b00, 1'b1), 1'b0);
      else       apply(idle_t(), 1'b0);
    end
  endtask

  task automatic test_clr();
    @(negedge clk); apply(mk(1'b1, '0, {NS{9'h1FF}}, '0, {NS{9'h001}}, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0), 1'b0);
    @(negedge clk); apply(mk(1'b1, '0, 45'd1, '0, 45'd7, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 1'b1);
    @(negedge clk); apply(idle_t(), 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b want 1", out_valid); end
    checks++; if (p !== '0) begin errors++; $display("FAIL clr_p: got %h want 0", p); end
    checks++; if (carry_out !== '0) begin errors++; $display("FAIL clr_carry: got %b want 0", carry_out); end
    @(negedge clk);
    checks++; if (p !== 45'd8) begin errors++; $display("FAIL clr_capture_p: got %h want %h", p, 45'd8); end
  endtask

  task automatic test_random();
    txn_t          q[$];
    txn_t          t, d;
    logic [DW-1:0] p_m, r;
    logic [NS-1:0] c_m, co;
    @(negedge clk); apply(idle_t(), 1'b1);
    @(negedge clk); apply(idle_t(), 1'b0);
    p_m = '0;
    c_m = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q.size() == 2) begin
        d = q.pop_front();
        if (d.v) begin
          model_calc(d, p_m, r, co);
          p_m = r;
          c_m = co;
        end
        checks++; if (out_valid !== d.v) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", k, out_valid, d.v); end
        checks++; if (p !== p_m) begin errors++; $display("FAIL rand_p@%0d: got %h want %h", k, p, p_m); end
        checks++; if (carry_out !== c_m) begin errors++; $display("FAIL rand_carry@%0d: got %b want %b", k, carry_out, c_m); end
      end
      t = mk($urandom_range(0, 9) < 7, rand_word(), rand_word(), rand_word(), rand_word(),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) t.x = '1;
      if ($urandom_range(0, 5) == 0) t.w = '0;
      if (t.op == 2'b00 && $urandom_range(0, 3) == 0) t.op = 2'b00;
      else if ($urandom_range(0, 1) == 0) t.op = 2'b00;
      apply(t, 1'b0);
      q.push_back(t);
    end
    @(negedge clk); apply(idle_t(), 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); apply(mk(1'b1, '0, 45'd1, '0, 45'd5, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 1'b0);
    @(negedge clk); apply(mk(1'b1, '0, 45'd2, '0, 45'd5, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0), 1'b0);
    @(negedge clk); apply(idle_t(), 1'b0);
    checks++; if (out_valid !== 1'b1 || p !== 45'd6) begin errors++; $display("FAIL mid_pre: got valid=%b p=%h want valid=1 p=%h", out_valid, p, 45'd6); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (p !== '0) begin errors++; $display("FAIL mid_p: got %h want 0", p); end
    checks++; if (carry_out !== '0) begin errors++; $display("FAIL mid_carry: got %b want 0", carry_out); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || p !== '0) begin errors++; $display("FAIL mid_after%0d: got valid=%b p=%h want valid=0 p=0", i, out_valid, p); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_full_sum();
    test_lane_isolation();
    test_two_lane_sub();
    test_logic();
    test_accumulate();
    test_clr();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
